mux_estru_4to1: RTL and testbench

//  - Gate-level 4:1 multiplexer. Selects one of four data lanes D[0..3] via 2-bit select S.
//  - Provides a combinational output Y and a registered copy Y_r for clocked consumers.
//  - Leaf datapath cell used wherever a structural, gate-built selector is required.

---
 rtl/mux_estru_pkg.sv | 12 +
 rtl/mux_estru_4to1_if.sv | 31 +++
 rtl/dec2to4.sv | 22 ++
 rtl/mux_estru_4to1.sv | 59 +++++
 tb/tb_mux_estru_4to1.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/mux_estru_pkg.sv
// Shared constants for the structural 4:1 multiplexer: lane count and the
// select codes that name each lane.
package mux_estru_pkg;

  localparam int       NUM_LANES = 4;

  localparam logic [1:0] SEL_L0 = 2'b00;
  localparam logic [1:0] SEL_L1 = 2'b01;
  localparam logic [1:0] SEL_L2 = 2'b10;
  localparam logic [1:0] SEL_L3 = 2'b11;

endpackage : mux_estru_pkg

// File: rtl/mux_estru_4to1_if.sv
// Bundle of the multiplexer's data-side signals. The producer of lanes and
// select uses the master view; the multiplexer itself uses the slave view.
interface mux_estru_4to1_if
  import mux_estru_pkg::*;
#(
  parameter int WIDTH = 1
);

  logic [NUM_LANES*WIDTH-1:0] D;       // packed lanes, lane 0 in the LSBs
  logic [1:0]                 S;       // lane select
  logic [WIDTH-1:0]           Y;       // combinational selected lane
  logic [WIDTH-1:0]           Y_r;     // registered selected lane
  logic [NUM_LANES-1:0]       sel_oh;  // one-hot decode of S

  modport master (
    output D,
    output S,
    input  Y,
    input  Y_r,
    input  sel_oh
  );

  modport slave (
    input  D,
    input  S,
    output Y,
    output Y_r,
    output sel_oh
  );

endinterface : mux_estru_4to1_if

// File: rtl/dec2to4.sv
// Gate-level 2-to-4 decoder: two inverters feed four 2-input ANDs, so that
// exactly one output is high for every select value.
module dec2to4
  import mux_estru_pkg::*;
(
  input  logic [1:0]           i_s,
  output wire  [NUM_LANES-1:0] o_sel_oh
);

  wire w_s0_n;
  wire w_s1_n;

  not u_inv_s0 (w_s0_n, i_s[0]);
  not u_inv_s1 (w_s1_n, i_s[1]);

  // Lane k is selected when the select bits match the binary code of k.
  and u_and_l0 (o_sel_oh[0], w_s1_n, w_s0_n);
  and u_and_l1 (o_sel_oh[1], w_s1_n, i_s[0]);
  and u_and_l2 (o_sel_oh[2], i_s[1], w_s0_n);
  and u_and_l3 (o_sel_oh[3], i_s[1], i_s[0]);

endmodule : dec2to4

// File: rtl/mux_estru_4to1.sv
// Structural 4:1 multiplexer. The select is decoded to one-hot, each output
// bit is an AND-OR of the decoder terms with the matching lane bits, and a
// registered copy of the result is kept for clocked consumers.
module mux_estru_4to1
  import mux_estru_pkg::*;
#(
  parameter int WIDTH = 1
)(
  input  logic              clk,
  input  logic              rst_n,
  mux_estru_4to1_if.slave   bus
);

  wire  [NUM_LANES-1:0]       w_sel_oh;
  wire  [WIDTH-1:0]           w_y;
  wire  [NUM_LANES*WIDTH-1:0] w_d;
  logic [WIDTH-1:0]           r_y;

  assign w_d = bus.D;

  dec2to4 u_dec (
    .i_s      (bus.S),
    .o_sel_oh (w_sel_oh)
  );

  // Per output bit: gate each lane bit with its decoder term, then OR the
  // four products through a two-level tree.
  genvar b;
  generate
    for (b = 0; b < WIDTH; b++) begin : g_bit
      wire [NUM_LANES-1:0] w_term;
      wire                 w_or01;
      wire                 w_or23;

      and u_and0 (w_term[0], w_sel_oh[0], w_d[0*WIDTH+b]);
      and u_and1 (w_term[1], w_sel_oh[1], w_d[1*WIDTH+b]);
      and u_and2 (w_term[2], w_sel_oh[2], w_d[2*WIDTH+b]);
      and u_and3 (w_term[3], w_sel_oh[3], w_d[3*WIDTH+b]);

      or  u_or01 (w_or01, w_term[0], w_term[1]);
      or  u_or23 (w_or23, w_term[2], w_term[3]);
      or  u_or   (w_y[b], w_or01, w_or23);
    end
  endgenerate

  // Capture the selected lane on each rising edge; reset clears it at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y <= {WIDTH{1'b0}};
    end else begin
      r_y <= w_y;
    end
  end

  assign bus.Y      = w_y;
  assign bus.sel_oh = w_sel_oh;
  assign bus.Y_r    = r_y;

endmodule : mux_estru_4to1

// File: tb/tb_mux_estru_4to1.sv
// Self-checking bench for mux_estru_4to1 at WIDTH=1 and WIDTH=8. Expected
// values are computed from a shift-and-mask lane model, queued when stimulus
// is applied and compared when the outputs are sampled.
module tb_mux_estru_4to1;
  import mux_estru_pkg::*;

  localparam int SIG_Y1  = 0;
  localparam int SIG_OH1 = 1;
  localparam int SIG_YR1 = 2;
  localparam int SIG_Y8  = 3;
  localparam int SIG_OH8 = 4;
  localparam int SIG_YR8 = 5;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  sb_t  sb_q[$];

  always #5 clk = ~clk;

  mux_estru_4to1_if #(.WIDTH(1)) if1 ();
  mux_estru_4to1_if #(.WIDTH(8)) if8 ();

  mux_estru_4to1 #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  mux_estru_4to1 #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

  function automatic logic [31:0] lane_model(logic [31:0] d, int s, int w);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    return (d >> (s * w)) & mask;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int sig, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_drain();
    sb_t         e;
    logic [31:0] got;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sig)
        SIG_Y1:  got = {31'd0, if1.Y};
        SIG_OH1: got = {28'd0, if1.sel_oh};
        SIG_YR1: got = {31'd0, if1.Y_r};
        SIG_Y8:  got = {24'd0, if8.Y};
        SIG_OH8: got = {28'd0, if8.sel_oh};
        SIG_YR8: got = {24'd0, if8.Y_r};
        default: got = 32'hDEAD_BEEF;
      endcase
      check_val(e.tag, got, e.exp);
    end
  endtask

  // Drive the 1-bit instance, check Y/sel_oh, then Y_r one edge later.
  task automatic step1(input string tag, input logic [3:0] d, input int s);
    logic [31:0] ey;
    if1.D = d;
    if1.S = s[1:0];
    ey = lane_model({28'd0, d}, s, 1);
    #1;
    sb_push($sformatf("%s_y_s%0d", tag, s), SIG_Y1, ey);
    sb_push($sformatf("%s_oh_s%0d", tag, s), SIG_OH1, 32'd1 << s);
    sb_drain();
    @(posedge clk);
    #1;
    sb_push($sformatf("%s_yr_s%0d", tag, s), SIG_YR1, ey);
    sb_drain();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d8;
    rst_n  = 1'b0;
    if1.D  = 4'b0011;
    if1.S  = SEL_L0;
    if8.D  = 32'd0;
    if8.S  = SEL_L0;

    // Reset state, and Y valid while in reset
    #2;
    sb_push("rst_yr1", SIG_YR1, 32'd0);
    sb_push("rst_yr8", SIG_YR8, 32'd0);
    sb_push("rst_y1",  SIG_Y1,  32'd1);
    sb_drain();
    @(posedge clk);
    #1;
    sb_push("rst_yr1_edge", SIG_YR1, 32'd0);
    sb_drain();
    @(negedge clk);
    rst_n = 1'b1;

    // D=0011 and D=1100 select sweeps
    for (int s = 0; s < 4; s++) step1("d0011", 4'b0011, s);
    for (int s = 0; s < 4; s++) step1("d1100", 4'b1100, s);

    // WIDTH=8, lane 2
    d8 = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    if8.D = d8;
    if8.S = SEL_L2;
    #1;
    sb_push("w8_y",  SIG_Y8,  lane_model(d8, 2, 8));
    sb_push("w8_oh", SIG_OH8, 32'd4);
    sb_drain();
    @(posedge clk);
    #1;
    sb_push("w8_yr", SIG_YR8, 32'h0000_00CC);
    sb_drain();

    // Asynchronous reset between edges, then reload on the next edge
    #2;
    rst_n = 1'b0;
    #1;
    sb_push("arst_yr8", SIG_YR8, 32'd0);
    sb_push("arst_y8",  SIG_Y8,  32'h0000_00CC);
    sb_drain();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    sb_push("rel_yr8_hold", SIG_YR8, 32'd0);
    sb_drain();
    @(posedge clk);
    #1;
    sb_push("rel_yr8_load", SIG_YR8, 32'h0000_00CC);
    sb_drain();

    // Only the value present at the edge is captured
    @(negedge clk);
    if8.S = SEL_L1;
    #2;
    if8.S = SEL_L3;
    @(posedge clk);
    #1;
    sb_push("edge_yr8", SIG_YR8, lane_model(d8, 3, 8));
    if8.S = SEL_L0;
    #1;
    sb_push("edge_y8_after", SIG_Y8, lane_model(d8, 0, 8));
    sb_push("edge_yr8_keep", SIG_YR8, 32'h0000_00DD);
    sb_drain();

    // Hold S=01: lane 1 changes propagate, other lanes do not
    @(negedge clk);
    if8.S = SEL_L1;
    d8 = {8'hDD, 8'hCC, 8'h55, 8'hAA};
    if8.D = d8;
    #1;
    sb_push("l1_tog_y8", SIG_Y8, lane_model(d8, 1, 8));
    sb_drain();
    d8 = {8'h22, 8'h11, 8'h55, 8'h00};
    if8.D = d8;
    #1;
    sb_push("other_tog_y8", SIG_Y8, 32'h0000_0055);
    sb_drain();
    d8 = {8'h22, 8'h11, 8'hA3, 8'h00};
    if8.D = d8;
    #1;
    sb_push("l1_tog2_y8", SIG_Y8, lane_model(d8, 1, 8));
    sb_drain();

    // Exhaustive WIDTH=1 sweep of all {D,S}
    for (int c = 0; c < 64; c++) begin
      logic [5:0] cv;
      cv = c[5:0];
      if1.D = cv[5:2];
      if1.S = cv[1:0];
      #1;
      sb_push($sformatf("ex_y_c%0d", c),  SIG_Y1,  lane_model({28'd0, cv[5:2]}, int'(cv[1:0]), 1));
      sb_push($sformatf("ex_oh_c%0d", c), SIG_OH1, 32'd1 << cv[1:0]);
      sb_drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mux_estru_4to1
